// File: rtl/rib_pkg.sv
// rib_pkg: shared constants and types for the RIB bus arbiter.
//   RIB_NUM_MASTERS : default requester count.
//   M_CPU..M_SPARE  : fixed master indices on req_i/grant_o.
//   rib_arb_state_e : arbiter FSM state.
package rib_pkg;
    localparam int RIB_NUM_MASTERS = 4;
    localparam int M_CPU   = 0;
    localparam int M_DMA   = 1;
    localparam int M_DBG   = 2;
    localparam int M_SPARE = 3;
    typedef enum logic {ARB_IDLE, ARB_OWNED} rib_arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority finder.
//   req_i   : request vector
//   ptr_i   : highest-priority index; search runs ptr_i, ptr_i+1, ... modulo N
//   excl_i  : masters removed from the search
//   found_o : some eligible request exists
//   idx_o   : first eligible index in search order
module rr_pick
    import rib_pkg::*;
#(
    parameter int N = RIB_NUM_MASTERS,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic [N-1:0]  excl_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);
    logic [N-1:0] elig;
    int           j;
    assign elig = req_i & ~excl_i;
    // Walk the search order backwards so the last hit is the earliest one.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N;
            if (elig[j]) begin
                found_o = 1'b1;
                idx_o   = IW'(j);
            end
        end
    end
endmodule

// File: rtl/rib_arbiter.sv
// rib_arbiter: round-robin RIB data-bus arbiter with burst limit and lock override.
//   clk         : system clock
//   rst         : asynchronous reset, active low
//   req_i       : per-master request (bit 0 = CPU data port)
//   lock_i      : per-master lock; owner's bit suspends the burst limit
//   grant_o     : registered one-hot grant, zero when idle
//   grant_id_o  : registered owner index, holds last owner while idle
//   busy_o      : registered, high while a grant is active
//   hold_o      : req_i & ~grant_o, per-master stall
//   hold_flag_o : hold_o[0], CPU pipeline hold
module rib_arbiter
    import rib_pkg::*;
#(
    parameter int NUM_MASTERS = RIB_NUM_MASTERS,
    parameter int MAX_BURST   = 16,
    localparam int IW = $clog2(NUM_MASTERS),
    localparam int CW = $clog2(MAX_BURST + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [NUM_MASTERS-1:0] lock_i,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic [IW-1:0]          grant_id_o,
    output logic                   busy_o,
    output logic [NUM_MASTERS-1:0] hold_o,
    output logic                   hold_flag_o
);
    localparam logic [IW-1:0] LAST = IW'(NUM_MASTERS - 1);
    localparam logic [CW-1:0] MAXB = CW'(MAX_BURST);

    rib_arb_state_e         state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          gid_q, gid_d, rr_q, rr_d, pick_idx;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   busy_q, busy_d, others, keep, pick_found;

    // grant_q is zero in IDLE, so it doubles as the owner exclusion mask.
    rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req_i   (req_i),
        .ptr_i   (rr_q),
        .excl_i  (grant_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign others = |(req_i & ~grant_q);
    assign keep   = state_q == ARB_OWNED && req_i[gid_q] &&
                    (lock_i[gid_q] || cnt_q < MAXB || !others);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gid_d   = gid_q;
        rr_d    = rr_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        if (keep) begin
            cnt_d = cnt_q == MAXB ? cnt_q : cnt_q + CW'(1);
        end else if (pick_found) begin
            state_d = ARB_OWNED;
            grant_d = NUM_MASTERS'(1) << pick_idx;
            gid_d   = pick_idx;
            rr_d    = pick_idx == LAST ? '0 : pick_idx + IW'(1);
            busy_d  = 1'b1;
            cnt_d   = CW'(1);
        end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            rr_q    <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
            rr_q    <= rr_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_o     = grant_q;
    assign grant_id_o  = gid_q;
    assign busy_o      = busy_q;
    assign hold_o      = req_i & ~grant_q;
    assign hold_flag_o = hold_o[0];
endmodule

// File: tb/tb_rib_arbiter.sv
// tb_rib_arbiter: directed test of rib_arbiter against a behavioural model.
module tb_rib_arbiter;
    localparam int N  = 4;
    localparam int MB = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req_i = '0;
    logic [N-1:0] lock_i = '0;
    logic [N-1:0] grant_o, hold_o;
    logic [1:0]   grant_id_o;
    logic         busy_o, hold_flag_o;

    int n_chk = 0;
    int n_err = 0;

    // Model state: owner (-1 = idle), last owner, priority pointer, run length.
    int m_owner = -1;
    int m_last  = 0;
    int m_rr    = 0;
    int m_run   = 0;

    rib_arbiter #(.NUM_MASTERS(N), .MAX_BURST(MB)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .lock_i      (lock_i),
        .grant_o     (grant_o),
        .grant_id_o  (grant_id_o),
        .busy_o      (busy_o),
        .hold_o      (hold_o),
        .hold_flag_o (hold_flag_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owner <= -1;
            m_last  <= 0;
            m_rr    <= 0;
            m_run   <= 0;
        end else begin
            automatic bit others = 0;
            automatic int win = -1;
            for (int j = 0; j < N; j++)
                if (req_i[j] && j != m_owner) others = 1;
            if (m_owner >= 0 && req_i[m_owner] && (lock_i[m_owner] || m_run < MB || !others)) begin
                m_run <= (m_run + 1 > MB) ? MB : m_run + 1;
            end else begin
                for (int k = N - 1; k >= 0; k--)
                    if (req_i[(m_rr + k) % N] && (m_rr + k) % N != m_owner) win = (m_rr + k) % N;
                if (win >= 0) begin
                    m_owner <= win;
                    m_last  <= win;
                    m_rr    <= (win + 1) % N;
                    m_run   <= 1;
                end else begin
                    m_owner <= -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        automatic logic [N-1:0] eg = (m_owner >= 0) ? N'(1) << m_owner : '0;
        chk("model_grant", 32'(grant_o), 32'(eg));
        chk("model_gid", 32'(grant_id_o), 32'(m_last));
        chk("model_busy", 32'(busy_o), 32'(m_owner >= 0));
        chk("model_hold", 32'(hold_o), 32'(req_i & ~eg));
        chk("model_hflag", 32'(hold_flag_o), 32'(req_i[0] & ~eg[0]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b0;
        req_i = 4'b0101;
        tick();
        tick();
        chk("rst_grant", 32'(grant_o), 0);
        chk("rst_hold", 32'(hold_o), 32'h5);
        chk("rst_busy", 32'(busy_o), 0);
        rst = 1'b1;
        req_i = 4'b0001;
        tick();
        chk("first_grant", 32'(grant_o), 32'h1);
        chk("first_gid", 32'(grant_id_o), 0);
        chk("first_hflag", 32'(hold_flag_o), 0);
        req_i = '0;
        tick();
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        req_i = 4'b1111;
        tick();
        chk("rr_g0", 32'(grant_o), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            req_i = 4'b1111 & ~grant_o;
            tick();
            chk("rr_seq", 32'(grant_o), 32'(1 << (i % 4)));
        end
        req_i = '0;
        tick();
        chk("rr_idle", 32'(busy_o), 0);
        req_i = 4'b0010;
        tick();
        req_i = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("burst_keep", 32'(grant_o), 32'h2);
        end
        tick();
        chk("burst_hand", 32'(grant_o), 32'h4);
        chk("burst_hold", 32'(hold_o), 32'h2);
        req_i = '0;
        tick();
        req_i = 4'b0010;
        tick();
        chk("lock_start", 32'(grant_o), 32'h2);
        req_i = 4'b0110;
        lock_i = 4'b0010;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("lock_keep", 32'(grant_o), 32'h2);
        end
        lock_i = '0;
        tick();
        chk("lock_hand", 32'(grant_o), 32'h4);
        req_i = '0;
        tick();
        req_i = 4'b1000;
        tick();
        chk("idle_g3", 32'(grant_o), 32'h8);
        req_i = '0;
        tick();
        chk("idle_grant", 32'(grant_o), 0);
        chk("idle_busy", 32'(busy_o), 0);
        chk("idle_gid", 32'(grant_id_o), 3);
        req_i = 4'b0001;
        tick();
        chk("idle_new", 32'(grant_o), 32'h1);
        req_i = 4'b0100;
        tick();
        chk("ar_owner", 32'(grant_o), 32'h4);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("ar_grant", 32'(grant_o), 0);
        chk("ar_busy", 32'(busy_o), 0);
        chk("ar_gid", 32'(grant_id_o), 0);
        tick();
        rst = 1'b1;
        req_i = 4'b1100;
        tick();
        chk("ar_rrptr", 32'(grant_o), 32'h4);
        req_i = '0;
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
